// File: rtl/cram_loader_pkg.sv
// Shared EBOX CRAM definitions: geometry of the control RAM and the loader state encoding.
package cram_loader_pkg;

    localparam int CRAM_ADDR_W    = 11;
    localparam int CRAM_DATA_W    = 84;
    localparam int BYTES_PER_WORD = (CRAM_DATA_W + 7) / 8;

    typedef enum logic [2:0] {
        CNT_LO = 3'd0,
        CNT_HI = 3'd1,
        DATA   = 3'd2,
        WRITE  = 3'd3,
        DONE   = 3'd4,
        ERROR  = 3'd5
    } loaderState_t;

endpackage

// File: rtl/cram_loader_word_asm.sv
// Byte-to-word assembler: shifts stream bytes in LSB-first and tracks the byte index.
module cram_word_asm #(
    parameter int BYTES_PER_WORD = cram_loader_pkg::BYTES_PER_WORD,
    parameter int IDX_W          = $clog2(BYTES_PER_WORD)
) (
    input  logic                        clk,
    input  logic                        CROBAR_N,
    input  logic                        clear,
    input  logic                        load,
    input  logic [7:0]                  din,
    output logic [8*BYTES_PER_WORD-1:0] word,
    output logic                        full
);
    import cram_loader_pkg::*;

    logic [IDX_W-1:0] idx;

    // Newest byte enters at the top, so after a full word byte 0 sits in bits [7:0].
    always_ff @(posedge clk or negedge CROBAR_N) begin
        if (!CROBAR_N) begin
            word <= '0;
            idx  <= '0;
        end else if (clear) begin
            word <= '0;
            idx  <= '0;
        end else if (load) begin
            word <= {din, word[8*BYTES_PER_WORD-1:8]};
            if (!full) begin
                idx <= idx + IDX_W'(1);
            end
        end
    end

    // Asserted while the next accepted byte completes the word.
    assign full = (idx == IDX_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/cram_loader.sv
// CRAM loader: parses a count-prefixed byte stream into CRAM writes and releases the EBOX when done.
//
//   state  | meaning
//   CNT_LO | waiting for count[7:0]
//   CNT_HI | waiting for count[15:8]; range-checks the count
//   DATA   | collecting the bytes of one CRAM word
//   WRITE  | one-cycle CRAM write strobe
//   DONE   | image loaded, EBOX released
//   ERROR  | malformed stream, sticky until start
module cram_loader #(
    parameter int CRAM_ADDR_W    = cram_loader_pkg::CRAM_ADDR_W,
    parameter int CRAM_DATA_W    = cram_loader_pkg::CRAM_DATA_W,
    parameter int BYTES_PER_WORD = (CRAM_DATA_W + 7) / 8
) (
    input  logic                   clk,
    input  logic                   CROBAR_N,
    input  logic                   start,
    input  logic [7:0]             inData,
    input  logic                   inValid,
    output logic                   inReady,
    output logic                   cramWrite,
    output logic [CRAM_ADDR_W-1:0] cramAddr,
    output logic [CRAM_DATA_W-1:0] cramData,
    output logic                   eboxReset,
    output logic                   done,
    output logic                   error
);
    import cram_loader_pkg::*;

    localparam int ASM_W     = 8 * BYTES_PER_WORD;
    localparam int LAST_BITS = CRAM_DATA_W - 8 * (BYTES_PER_WORD - 1);
    localparam int MAX_WORDS = 1 << CRAM_ADDR_W;

    loaderState_t           state;
    logic [7:0]             countLo;
    logic [15:0]            lastAddr;
    logic [CRAM_ADDR_W-1:0] addr;
    logic [ASM_W-1:0]       asmWord;
    logic                   asmFull;
    logic                   asmLoad;
    logic                   asmClear;
    logic                   xfer;
    logic                   badTop;
    logic                   countOk;
    logic [15:0]            countFull;
    logic                   unusedAsmTop;

    assign xfer      = inValid && inReady;
    assign countFull = {inData, countLo};
    assign countOk   = (countFull != 16'd0) && (countFull <= 16'(MAX_WORDS));
    // Bits of the last byte beyond the CRAM width must be zero.
    assign badTop    = (inData >> LAST_BITS) != 8'd0;
    assign asmLoad   = xfer && (state == DATA) && !(asmFull && badTop);
    assign asmClear  = (state == WRITE) || ((state == CNT_HI) && xfer);

    cram_word_asm #(
        .BYTES_PER_WORD(BYTES_PER_WORD)
    ) u_asm (
        .clk     (clk),
        .CROBAR_N(CROBAR_N),
        .clear   (asmClear),
        .load    (asmLoad),
        .din     (inData),
        .word    (asmWord),
        .full    (asmFull)
    );

    // The padding nibble of the last byte is rejected before it is loaded, so it is always zero here.
    assign unusedAsmTop = ^asmWord[ASM_W-1:CRAM_DATA_W];
    assign cramData     = asmWord[CRAM_DATA_W-1:0];
    assign cramAddr     = addr;

    always_ff @(posedge clk or negedge CROBAR_N) begin
        if (!CROBAR_N) begin
            state     <= CNT_LO;
            countLo   <= 8'd0;
            lastAddr  <= 16'd0;
            addr      <= '0;
            inReady   <= 1'b0;
            cramWrite <= 1'b0;
            eboxReset <= 1'b1;
            done      <= 1'b0;
            error     <= 1'b0;
        end else begin
            cramWrite <= 1'b0;
            case (state)
                CNT_LO: begin
                    inReady <= 1'b1;
                    if (xfer) begin
                        countLo <= inData;
                        state   <= CNT_HI;
                    end
                end
                CNT_HI: begin
                    if (xfer) begin
                        if (countOk) begin
                            lastAddr <= countFull - 16'd1;
                            addr     <= '0;
                            state    <= DATA;
                        end else begin
                            inReady <= 1'b0;
                            error   <= 1'b1;
                            state   <= ERROR;
                        end
                    end
                end
                DATA: begin
                    if (xfer && asmFull) begin
                        inReady <= 1'b0;
                        if (badTop) begin
                            error <= 1'b1;
                            state <= ERROR;
                        end else begin
                            cramWrite <= 1'b1;
                            state     <= WRITE;
                        end
                    end
                end
                WRITE: begin
                    if (16'(addr) == lastAddr) begin
                        eboxReset <= 1'b0;
                        done      <= 1'b1;
                        state     <= DONE;
                    end else begin
                        addr    <= addr + CRAM_ADDR_W'(1);
                        inReady <= 1'b1;
                        state   <= DATA;
                    end
                end
                DONE, ERROR: begin
                    if (start) begin
                        inReady   <= 1'b1;
                        eboxReset <= 1'b1;
                        done      <= 1'b0;
                        error     <= 1'b0;
                        state     <= CNT_LO;
                    end
                end
                default: begin
                    inReady <= 1'b0;
                    state   <= CNT_LO;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cram_loader.sv
// Randomized bench for cram_loader against a stream-level reference model.
module tb_cram_loader;

    logic        clk = 1'b0;
    logic        CROBAR_N = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  inData = 8'd0;
    logic        inValid = 1'b0;
    logic        inReady;
    logic        cramWrite;
    logic [10:0] cramAddr;
    logic [83:0] cramData;
    logic        eboxReset;
    logic        done;
    logic        error;

    int errors = 0;
    int checks = 0;

    logic [7:0]  stream[$];
    logic [94:0] expQ[$];
    logic [94:0] gotQ[$];
    bit          expDone;
    bit          expErr;
    int          nUse;

    cram_loader dut (
        .clk      (clk),
        .CROBAR_N (CROBAR_N),
        .start    (start),
        .inData   (inData),
        .inValid  (inValid),
        .inReady  (inReady),
        .cramWrite(cramWrite),
        .cramAddr (cramAddr),
        .cramData (cramData),
        .eboxReset(eboxReset),
        .done     (done),
        .error    (error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (CROBAR_N && cramWrite) gotQ.push_back({cramAddr, cramData});
    end

    task automatic checkVal(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Builds a stream of cnt words; badWord gets 0x1F as its last byte; addrData makes word value = address.
    task automatic makeStream(input int cnt, input int badWord, input bit addrData);
        logic [7:0] v;
        stream.delete();
        v = cnt[7:0];
        stream.push_back(v);
        v = cnt[15:8];
        stream.push_back(v);
        if (cnt >= 1 && cnt <= 2048) begin
            for (int w = 0; w < cnt; w++) begin
                for (int b = 0; b < 11; b++) begin
                    if (addrData) v = (b < 2) ? 8'((w >> (8 * b)) & 255) : 8'd0;
                    else          v = 8'($urandom_range(255));
                    if (b == 10) v = v & 8'h0F;
                    if (b == 10 && w == badWord) v = 8'h1F;
                    stream.push_back(v);
                end
            end
        end
    endtask

    // Reference: decode the stream by its format rules into expected writes and final status.
    task automatic buildExpect();
        int cnt;
        logic [87:0] acc;
        expQ.delete();
        expDone = 0;
        expErr  = 0;
        cnt = int'(stream[0]) + 256 * int'(stream[1]);
        nUse = 2;
        if (cnt == 0 || cnt > 2048) begin
            expErr = 1;
            return;
        end
        for (int w = 0; w < cnt; w++) begin
            acc = '0;
            for (int b = 0; b < 11; b++) begin
                nUse++;
                if (b == 10 && stream[2 + w * 11 + b] > 8'd15) begin
                    expErr = 1;
                    return;
                end
                acc = acc | (88'(stream[2 + w * 11 + b]) << (8 * b));
            end
            expQ.push_back({11'(w), acc[83:0]});
        end
        expDone = 1;
    endtask

    task automatic sendByte(input logic [7:0] b, input int gapPct, output bit ok);
        ok = 0;
        for (int t = 0; t < 64; t++) begin
            @(negedge clk);
            if (int'($urandom_range(99)) < gapPct) begin
                inValid = 1'b0;
                inData  = 8'($urandom);
            end else begin
                inValid = 1'b1;
                inData  = b;
                if (inReady) begin
                    ok = 1;
                    return;
                end
            end
        end
    endtask

    task automatic runStream(input int gapPct, input string name);
        bit ok;
        bit allOk;
        int bad;
        int n;
        allOk = 1;
        gotQ.delete();
        buildExpect();
        for (int i = 0; i < nUse; i++) begin
            sendByte(stream[i], gapPct, ok);
            if (!ok) begin
                allOk = 0;
                break;
            end
        end
        @(negedge clk);
        if (gapPct == 0 && allOk) checkVal({name, ".latency"}, cramWrite, expErr ? 1'b0 : 1'b1);
        inValid = 1'b0;
        checkVal({name, ".accepted"}, allOk, 1'b1);
        repeat (3) @(negedge clk);
        checkVal({name, ".nWrites"}, gotQ.size(), expQ.size());
        n = (gotQ.size() < expQ.size()) ? gotQ.size() : expQ.size();
        if (expQ.size() <= 8) begin
            for (int i = 0; i < n; i++) checkVal($sformatf("%s.write%0d", name, i), gotQ[i], expQ[i]);
        end else begin
            bad = 0;
            for (int i = 0; i < n; i++) if (gotQ[i] !== expQ[i]) bad++;
            checkVal({name, ".dataMismatches"}, bad, 0);
        end
        checkVal({name, ".done"}, done, expDone);
        checkVal({name, ".error"}, error, expErr);
        checkVal({name, ".eboxReset"}, eboxReset, !expDone);
    endtask

    task automatic startPulse(input string name);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkVal({name, ".done"}, done, 1'b0);
        checkVal({name, ".error"}, error, 1'b0);
        checkVal({name, ".eboxReset"}, eboxReset, 1'b1);
        checkVal({name, ".inReady"}, inReady, 1'b1);
    endtask

    initial begin
        bit ok;
        int zeroWrites;

        repeat (2) @(negedge clk);
        checkVal("rst.inReady", inReady, 1'b0);
        checkVal("rst.cramWrite", cramWrite, 1'b0);
        checkVal("rst.done", done, 1'b0);
        checkVal("rst.error", error, 1'b0);
        checkVal("rst.eboxReset", eboxReset, 1'b1);
        CROBAR_N = 1'b1;
        @(negedge clk);
        checkVal("rel.inReady", inReady, 1'b1);

        // start is ignored in CNT_LO
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkVal("ignStart.inReady", inReady, 1'b1);
        checkVal("ignStart.done", done, 1'b0);

        // count=1, bytes 01..0B
        stream.delete();
        stream.push_back(8'h01);
        stream.push_back(8'h00);
        for (int b = 1; b <= 11; b++) stream.push_back(8'(b));
        runStream(0, "one");
        if (gotQ.size() > 0) checkVal("one.literal", gotQ[0], {11'd0, 84'hB0A090807060504030201});

        startPulse("start1");
        makeStream(3, -1, 0);
        runStream(40, "rand3");

        startPulse("start2");
        makeStream(5, -1, 0);
        runStream(20, "rand5");

        startPulse("start3");
        makeStream(0, -1, 0);
        runStream(0, "cnt0");
        startPulse("start4");
        makeStream(16'h0801, -1, 0);
        runStream(10, "cnt801");
        startPulse("start5");

        makeStream(2, 1, 0);
        runStream(0, "badTop");
        startPulse("start6");

        // reset after 5 bytes of word 2
        makeStream(4, -1, 0);
        for (int i = 0; i < 2 + 22 + 5; i++) sendByte(stream[i], 0, ok);
        @(posedge clk);
        #2;
        inValid  = 1'b0;
        CROBAR_N = 1'b0;
        #1;
        checkVal("midRst.cramWrite", cramWrite, 1'b0);
        checkVal("midRst.inReady", inReady, 1'b0);
        checkVal("midRst.done", done, 1'b0);
        checkVal("midRst.error", error, 1'b0);
        checkVal("midRst.eboxReset", eboxReset, 1'b1);
        checkVal("midRst.cramAddr", cramAddr, 11'd0);
        checkVal("midRst.cramData", cramData, 84'd0);
        repeat (2) @(negedge clk);
        CROBAR_N = 1'b1;
        @(negedge clk);
        checkVal("midRst.inReadyAfter", inReady, 1'b1);
        makeStream(2, -1, 0);
        runStream(30, "reload");

        startPulse("start7");
        makeStream(2048, -1, 1);
        runStream(0, "full2048");
        if (gotQ.size() > 0) checkVal("full2048.lastAddr", gotQ[gotQ.size() - 1][94:84], 11'd2047);
        zeroWrites = 0;
        foreach (gotQ[i]) if (gotQ[i][94:84] == 11'd0) zeroWrites++;
        checkVal("full2048.addr0Writes", zeroWrites, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
